// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants, encoder state enum and range-check helper.
// Latency: none (package only).
// Backpressure: not applicable.
package riscv_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // ADDI x0,x0,0
   localparam logic [31:0] NOP_ENC = 32'h00000013;

   localparam logic [2:0] F3_ADDI = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SRX  = 3'b101;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OUT   = 2'd1,
      LI_HI = 2'd2,
      LI_LO = 2'd3
   } state_e;

   // True when v is representable as a 'bits'-wide two's complement value,
   // i.e. every bit from bits-1 upward equals the sign bit.
   function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
      logic [31:0] s;
      s = $signed(v) >>> (bits - 1);
      return (s == '0) || (s == '1);
   endfunction

endpackage

// File: rtl/imm_pack.sv
// Packs request fields into one RV32I instruction and flags illegal immediates/opcodes.
// Latency: purely combinational.
// Backpressure: none; the caller owns the handshake.
module imm_pack
   import riscv_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
   input  logic [6:0]  i_opcode,
   input  logic [4:0]  i_rd,
   input  logic [4:0]  i_rs1,
   input  logic [4:0]  i_rs2,
   input  logic [2:0]  i_funct3,
   input  logic [6:0]  i_funct7,
   input  logic [31:0] i_imm,
   output logic [31:0] o_instr,
   output logic        o_err
);

   logic [31:0] raw;
   logic        bad;

   // Format selection by opcode; an error replaces the whole word with the NOP.
   always_comb begin
      raw = '0;
      bad = 1'b0;
      unique case (i_opcode)
         OPC_LOAD, OPC_JALR, OPC_OPIMM: begin
            if (i_opcode == OPC_OPIMM && (i_funct3 == F3_SLL || i_funct3 == F3_SRX)) begin
               // Shift amount lives in the rs2 slot, funct7 selects SRL/SRA.
               raw = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, i_opcode};
               bad = |i_imm[31:5];
            end else begin
               raw = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
               bad = !fits_signed(i_imm, 12);
            end
         end
         OPC_STORE: begin
            raw = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
            bad = !fits_signed(i_imm, 12);
         end
         OPC_BRANCH: begin
            raw = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3, i_imm[4:1], i_imm[11], i_opcode};
            bad = !fits_signed(i_imm, 13) || i_imm[0];
         end
         OPC_JAL: begin
            raw = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
            bad = !fits_signed(i_imm, 21) || i_imm[0];
         end
         OPC_LUI, OPC_AUIPC: begin
            raw = {i_imm[31:12], i_rd, i_opcode};
            bad = |i_imm[11:0];
         end
         OPC_OP: begin
            raw = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
            bad = 1'b0;
         end
         default: begin
            raw = '0;
            bad = 1'b1;
         end
      endcase
      o_instr = bad ? NOP_INSTR : raw;
      o_err   = bad;
   end

endmodule

// File: rtl/imm_encode.sv
// Sequential RV32I encoder with LI -> LUI+ADDI expansion behind a valid/ready handshake.
// Latency: first beat registered one cycle after accept; LI may add a second beat.
// Backpressure: output beat held stable while i_ready=0; o_ready only on idle or final-beat handshake.
module imm_encode
   import riscv_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic        i_li,
   input  logic [6:0]  i_opcode,
   input  logic [4:0]  i_rd,
   input  logic [4:0]  i_rs1,
   input  logic [4:0]  i_rs2,
   input  logic [2:0]  i_funct3,
   input  logic [6:0]  i_funct7,
   input  logic [31:0] i_imm,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_instr,
   output logic        o_err,
   output logic        o_last
);

   state_e      state_q;
   logic        valid_q;
   logic [31:0] instr_q;
   logic        err_q;
   logic        last_q;
   logic [31:0] lo_q;

   logic [31:0] pack_instr;
   logic        pack_err;

   logic [19:0] li_hi;
   logic [31:0] req_instr;
   logic        req_err;
   state_e      req_state;
   logic [31:0] req_lo;

   logic        accept;
   logic        handshake;

   imm_pack #(
      .NOP_INSTR (NOP_INSTR)
   ) u_pack (
      .i_opcode (i_opcode),
      .i_rd     (i_rd),
      .i_rs1    (i_rs1),
      .i_rs2    (i_rs2),
      .i_funct3 (i_funct3),
      .i_funct7 (i_funct7),
      .i_imm    (i_imm),
      .o_instr  (pack_instr),
      .o_err    (pack_err)
   );

   assign handshake = valid_q && i_ready;
   assign o_ready   = (state_q == IDLE) || (handshake && last_q);
   assign accept    = i_valid && o_ready;

   // Upper LUI part is rounded up when the low 12 bits will be sign-extended negative.
   assign li_hi = i_imm[31:12] + {19'd0, i_imm[11]};

   // First beat of the incoming request; LI overrides the packer result.
   always_comb begin
      req_instr = pack_instr;
      req_err   = pack_err;
      req_state = OUT;
      req_lo    = '0;
      if (i_li) begin
         req_err = 1'b0;
         if (fits_signed(i_imm, 12)) begin
            req_instr = {i_imm[11:0], 5'd0, F3_ADDI, i_rd, OPC_OPIMM};
         end else if (i_imm[11:0] == 12'd0) begin
            req_instr = {li_hi, i_rd, OPC_LUI};
         end else begin
            req_instr = {li_hi, i_rd, OPC_LUI};
            req_state = LI_HI;
            req_lo    = {i_imm[11:0], i_rd, F3_ADDI, i_rd, OPC_OPIMM};
         end
      end
   end

   // Output register and beat sequencing; a new accept always wins over a return to IDLE.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         instr_q <= '0;
         err_q   <= 1'b0;
         last_q  <= 1'b0;
         lo_q    <= '0;
      end else if (accept) begin
         state_q <= req_state;
         valid_q <= 1'b1;
         instr_q <= req_instr;
         err_q   <= req_err;
         last_q  <= (req_state == OUT);
         lo_q    <= req_lo;
      end else if (handshake) begin
         if (state_q == LI_HI) begin
            state_q <= LI_LO;
            instr_q <= lo_q;
            err_q   <= 1'b0;
            last_q  <= 1'b1;
         end else begin
            state_q <= IDLE;
            valid_q <= 1'b0;
         end
      end
   end

   assign o_valid = valid_q;
   assign o_instr = instr_q;
   assign o_err   = err_q;
   assign o_last  = last_q;

endmodule

// File: tb/tb_imm_encode.sv
// Directed self-checking bench for imm_encode with hand-computed encodings.
// Latency: checks first beat one cycle after accept, back-to-back issue, LI two-beat sequencing.
// Backpressure: exercises i_ready=0 hold on the LUI beat and reset in the middle of LI.
module tb_imm_encode;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_valid;
   logic        o_ready;
   logic        i_li;
   logic [6:0]  i_opcode;
   logic [4:0]  i_rd;
   logic [4:0]  i_rs1;
   logic [4:0]  i_rs2;
   logic [2:0]  i_funct3;
   logic [6:0]  i_funct7;
   logic [31:0] i_imm;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_instr;
   logic        o_err;
   logic        o_last;

   int n_checks = 0;
   int n_fail   = 0;

   imm_encode dut (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_li     (i_li),
      .i_opcode (i_opcode),
      .i_rd     (i_rd),
      .i_rs1    (i_rs1),
      .i_rs2    (i_rs2),
      .i_funct3 (i_funct3),
      .i_funct7 (i_funct7),
      .i_imm    (i_imm),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_instr  (o_instr),
      .o_err    (o_err),
      .o_last   (o_last)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h, required %h", tag, got, exp);
      end
   endtask

   task automatic set_req(input logic li, input logic [6:0] opc, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] imm);
      i_li     = li;
      i_opcode = opc;
      i_rd     = rd;
      i_rs1    = rs1;
      i_rs2    = rs2;
      i_funct3 = f3;
      i_funct7 = f7;
      i_imm    = imm;
      i_valid  = 1'b1;
   endtask

   // Check the beat presented now (called at a negedge).
   task automatic check_beat(input string tag, input logic [31:0] instr,
                             input logic err, input logic last);
      check({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
      check({tag, "_instr"}, o_instr, instr);
      check({tag, "_err"},   {31'd0, o_err},   {31'd0, err});
      check({tag, "_last"},  {31'd0, o_last},  {31'd0, last});
   endtask

   // Single-beat request issued at a negedge with i_ready=1; beat checked one cycle later.
   task automatic single(input string tag, input logic li, input logic [6:0] opc,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                         input logic [31:0] exp_instr, input logic exp_err);
      int n;
      set_req(li, opc, rd, rs1, rs2, f3, f7, imm);
      n = 0;
      while (!o_ready && n < 20) begin
         @(negedge i_clk);
         n++;
      end
      check({tag, "_ready"}, {31'd0, o_ready}, 32'd1);
      @(posedge i_clk);
      @(negedge i_clk);
      i_valid = 1'b0;
      check_beat(tag, exp_instr, exp_err, 1'b1);
      @(posedge i_clk);
      @(negedge i_clk);
      check({tag, "_drain"}, {31'd0, o_valid}, 32'd0);
   endtask

   initial begin
      i_rst_n = 1'b0;
      i_ready = 1'b1;
      i_valid = 1'b0;
      set_req(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      i_valid = 1'b0;
      #12;
      check("rst_valid", {31'd0, o_valid}, 32'd0);
      check("rst_instr", o_instr, 32'd0);
      check("rst_err",   {31'd0, o_err},   32'd0);
      check("rst_last",  {31'd0, o_last},  32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      // Main formats and error substitution
      single("lw",      1'b0, 7'b0000011, 5'd5, 5'd2, 5'd0, 3'b010, 7'd0, 32'd8,         32'h00812283, 1'b0);
      single("addi_m",  1'b0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFFF800, 32'h80000093, 1'b0);
      single("addi_ov", 1'b0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048,      32'h00000013, 1'b1);
      single("slli",    1'b0, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'b001, 7'd0, 32'd31,        32'h01F11093, 1'b0);
      single("slli_ov", 1'b0, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'b001, 7'd0, 32'd32,        32'h00000013, 1'b1);
      single("br_odd",  1'b0, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd3,         32'h00000013, 1'b1);
      single("bad_opc", 1'b0, 7'b0000000, 5'd1, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0,         32'h00000013, 1'b1);
      single("lui_lo",  1'b0, 7'b0110111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345001, 32'h00000013, 1'b1);
      single("add",     1'b0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'hDEADBEEF, 32'h002081B3, 1'b0);
      single("li_small",1'b1, 7'b0000000, 5'd3, 5'd9, 5'd9, 3'b111, 7'd0, 32'd5,         32'h00500193, 1'b0);
      single("li_lui",  1'b1, 7'b0000000, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345000, 32'h123450B7, 1'b0);

      // Back-to-back SW then JAL, no bubble
      set_req(1'b0, 7'b0100011, 5'd0, 5'd2, 5'd6, 3'b010, 7'd0, 32'hFFFFFFFC);
      @(posedge i_clk);
      @(negedge i_clk);
      check_beat("sw", 32'hFE612E23, 1'b0, 1'b1);
      check("sw_ready", {31'd0, o_ready}, 32'd1);
      set_req(1'b0, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h00000800);
      @(posedge i_clk);
      @(negedge i_clk);
      i_valid = 1'b0;
      check_beat("jal", 32'h001000EF, 1'b0, 1'b1);
      @(posedge i_clk);
      @(negedge i_clk);
      check("jal_drain", {31'd0, o_valid}, 32'd0);

      // LI with backpressure on the LUI beat; a pending request must wait
      i_ready = 1'b0;
      set_req(1'b1, 7'd0, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF);
      @(posedge i_clk);
      @(negedge i_clk);
      set_req(1'b1, 7'd0, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      for (int c = 0; c < 3; c++) begin
         check_beat("li_hi_hold", 32'h12346537, 1'b0, 1'b0);
         check("li_hi_ready", {31'd0, o_ready}, 32'd0);
         @(posedge i_clk);
         @(negedge i_clk);
      end
      i_ready = 1'b1;
      check("li_hi_rel_ready", {31'd0, o_ready}, 32'd0);
      @(posedge i_clk);
      @(negedge i_clk);
      check_beat("li_lo", 32'hFFF50513, 1'b0, 1'b1);
      check("li_lo_ready", {31'd0, o_ready}, 32'd1);
      @(posedge i_clk);
      @(negedge i_clk);
      i_valid = 1'b0;
      check_beat("li_next", 32'h00500193, 1'b0, 1'b1);
      @(posedge i_clk);
      @(negedge i_clk);
      check("li_drain", {31'd0, o_valid}, 32'd0);

      // Reset while the LUI beat is pending
      i_ready = 1'b0;
      set_req(1'b1, 7'd0, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF);
      @(posedge i_clk);
      @(negedge i_clk);
      i_valid = 1'b0;
      check_beat("rst_pre", 32'h12346537, 1'b0, 1'b0);
      i_rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {31'd0, o_valid}, 32'd0);
      check("mid_rst_instr", o_instr, 32'd0);
      check("mid_rst_err",   {31'd0, o_err},   32'd0);
      check("mid_rst_last",  {31'd0, o_last},  32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      i_ready = 1'b1;
      check("post_rst_ready", {31'd0, o_ready}, 32'd1);
      for (int c = 0; c < 3; c++) begin
         @(posedge i_clk);
         @(negedge i_clk);
         check("post_rst_no_beat", {31'd0, o_valid}, 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imm_encode.md
Name: imm_encode

Overview:
Sequential RISC-V instruction encoder, the inverse of the immediate decoder. It accepts instruction fields (opcode, registers, funct, 32-bit immediate) over a valid/ready handshake. It range-checks the immediate and packs it into the format-specific bit positions of a 32-bit RV32I instruction. It also expands the LI pseudo-instruction into LUI+ADDI. It feeds the boot/trap-stub generator and the debug instruction injector ahead of the fetch mux.

Parameters:
NOP_INSTR, 32'h00000013, instruction emitted on any encoding error (ADDI x0,x0,0)

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  request valid
o_ready  output  1  block can accept a request this cycle
i_li  input  1  LI pseudo request; i_opcode, i_rs1, i_rs2, i_funct3 and i_funct7 are ignored
i_opcode  input  7  target opcode
i_rd  input  5  destination register
i_rs1  input  5  source register 1
i_rs2  input  5  source register 2
i_funct3  input  3  funct3
i_funct7  input  7  funct7, used for R-type and shift-immediate forms
i_imm  input  32  full immediate / byte offset, two's complement
o_valid  output  1  output beat valid
i_ready  input  1  downstream accepts the beat
o_instr  output  32  encoded instruction
o_err  output  1  beat is the NOP substitute for an illegal request
o_last  output  1  final beat of the current request

Behaviour:
- Reset (asynchronous, i_rst_n=0): o_valid=0, o_instr=0, o_err=0, o_last=0, state=IDLE.
- Reset mid-request: an in-flight or pending LI second beat is discarded.
- Accept condition: i_valid && o_ready.
- o_ready = (state==IDLE) || (o_valid && i_ready && o_last). This is combinational and allows back-to-back requests.
- Latency: a beat appears on o_valid the cycle after accept.
- Hold rule: o_instr, o_err and o_last stay stable while o_valid && !i_ready.
- States:
  - IDLE: no beat pending. Accept -> OUT.
  - OUT: single beat, o_last=1. Handshake done with no new accept -> IDLE; handshake done with a new accept -> reload the output register.
  - LI_HI: LUI beat, o_last=0. Handshake done -> LI_LO.
  - LI_LO: ADDI beat, o_last=1. Handshake done -> IDLE, or reload if a new request is accepted.
- Field placement (rd[11:7], rs1[19:15], rs2[24:20], funct3[14:12]):
  - I-type, opcodes 0000011, 1100111, 0010011: [31:20]=imm[11:0].
  - Error if imm is not the sign-extension of imm[11:0].
  - Shift-immediate (0010011 with funct3 001 or 101): [31:25]=funct7, [24:20]=imm[4:0]. Error if imm[31:5]!=0.
  - S-type (0100011): [31:25]=imm[11:5], [11:7]=imm[4:0]. Error if imm is outside the 12-bit signed range.
  - B-type (1100011): [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]. Error if imm is outside the 13-bit signed range or imm[0]=1.
  - J-type (1101111): [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]. Error if imm is outside the 21-bit signed range or imm[0]=1.
  - U-type (0110111, 0010111): [31:12]=imm[31:12]. Error if imm[11:0]!=0.
  - R-type (0110011): funct7 and rs2 fields; i_imm is ignored.
  - Any other opcode: error.
- Error handling: o_instr=NOP_INSTR, o_err=1, single beat with o_last=1.
- LI expansion:
  - imm within the 12-bit signed range: single ADDI rd,x0,imm[11:0] (state OUT).
  - Otherwise hi = imm[31:12] + imm[11], computed modulo 2^20.
  - If imm[11:0]==0: single LUI rd,hi.
  - Else: LUI rd,hi (LI_HI), then ADDI rd,rd,imm[11:0] (LI_LO).
  - The low-part immediate is latched at accept; the request fields need not be held.
  - LI never raises o_err.

Decomposition:
- Shared package (riscv_pkg):
  - Opcode constants OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_OPIMM, OPC_OP.
  - NOP encoding.
  - funct3 constants for shifts.
  - State enum.
- One natural sub-module, imm_pack: purely combinational, fields -> {instr, err}.
  - Instantiated once on the request path.
  - The FSM/output register and the LI sequencing live in imm_encode.

Test Plan:
1. LW x5,8(x2): opcode 0000011, rd=5, rs1=2, funct3=010, imm=8 -> one beat 0x00812283, o_err=0, o_last=1, one cycle after accept.
2. SW x6,-4(x2): imm=0xFFFFFFFC, rs2=6 -> 0xFE612E23. Then JAL x1,+2048 (imm=0x800) -> 0x001000EF, back-to-back with i_ready=1, no bubble.
3. Branch with imm=3, and separately opcode 0000000 -> each gives o_instr=0x00000013, o_err=1.
4. LI x10,0x12345FFF -> beat 0x12346537 (o_last=0), then 0xFFF50513 (o_last=1). LI x3,5 -> single 0x00500193.
5. Backpressure: hold i_ready=0 for 3 cycles on the LUI beat -> o_instr stable, o_ready=0, no new request accepted. Then release -> ADDI beat follows.
6. Assert i_rst_n=0 during LI_HI -> o_valid=0 immediately with all outputs 0. After release, o_ready=1 and no stale ADDI beat.
